// File: rtl/puzzle_vga_scanout_if.sv
// Pixel-write bus from the puzzle drawer into the scanout framebuffer.
// The drawer drives the master side; the scanout block consumes it.
interface puzzle_vga_scanout_if;
    logic        wr_en;
    logic [10:0] wr_x;
    logic [10:0] wr_y;
    logic        wr_color;

    modport master (output wr_en, wr_x, wr_y, wr_color);
    modport slave  (input  wr_en, wr_x, wr_y, wr_color);
endinterface

// File: rtl/puzzle_vga_scanout.sv
// 1-bit on-chip framebuffer for the puzzle play area plus 640x480@60 VGA scanout.
// Writes land in screen coordinates; pixels outside the stored region read as BG.
module puzzle_vga_scanout #(
    parameter int         X0          = 100,
    parameter int         Y0          = 30,
    parameter int         W           = 412,
    parameter int         H           = 412,
    parameter int         CLK_PER_PIX = 2,
    parameter logic [7:0] FG          = 8'hFF,
    parameter logic [7:0] BG          = 8'h00,
    parameter int         H_ACTIVE    = 640,
    parameter int         H_FP        = 16,
    parameter int         H_SYNC      = 96,
    parameter int         H_BP        = 48,
    parameter int         V_ACTIVE    = 480,
    parameter int         V_FP        = 10,
    parameter int         V_SYNC      = 2,
    parameter int         V_BP        = 33
) (
    input  logic                 clk,
    input  logic                 reset,
    puzzle_vga_scanout_if.slave  wr,
    output logic                 vga_hs,
    output logic                 vga_vs,
    output logic                 vga_blank_n,
    output logic [7:0]           vga_r,
    output logic [7:0]           vga_g,
    output logic [7:0]           vga_b,
    output logic                 frame_tick
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DEPTH   = W * H;
    localparam int ADDR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int DIV_W   = (CLK_PER_PIX > 1) ? $clog2(CLK_PER_PIX) : 1;

    localparam logic [10:0] X_LO      = 11'(X0);
    localparam logic [10:0] X_HI      = 11'(X0 + W);
    localparam logic [10:0] Y_LO      = 11'(Y0);
    localparam logic [10:0] Y_HI      = 11'(Y0 + H);
    localparam logic [10:0] H_ACT     = 11'(H_ACTIVE);
    localparam logic [10:0] H_SYNC_LO = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] H_SYNC_HI = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] H_LAST    = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_ACT     = 11'(V_ACTIVE);
    localparam logic [10:0] V_SYNC_LO = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] V_SYNC_HI = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [10:0] V_LAST    = 11'(V_TOTAL - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_PER_PIX - 1);

    logic [DIV_W-1:0]  div;
    logic              pix_en;
    logic [10:0]       hcount;
    logic [10:0]       vcount;
    logic              wr_hit;
    logic [ADDR_W-1:0] wr_addr;
    logic              pix_in_region;
    logic [ADDR_W-1:0] rd_addr;

    logic              a_load, a_tick, a_in, a_hs, a_vs, a_blank_n;
    logic [ADDR_W-1:0] a_addr;
    logic              b_tick, b_in, b_hs, b_vs, b_blank_n;
    logic              rd_data;
    logic              mem [0:DEPTH-1];
    logic [7:0]        pix_rgb;

    assign pix_en = (div == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div    <= '0;
            hcount <= '0;
            vcount <= '0;
        end else begin
            div <= (div == DIV_LAST) ? '0 : div + DIV_W'(1);
            if (pix_en) begin
                if (hcount == H_LAST) begin
                    hcount <= '0;
                    vcount <= (vcount == V_LAST) ? '0 : vcount + 11'd1;
                end else begin
                    hcount <= hcount + 11'd1;
                end
            end
        end
    end

    assign wr_hit  = wr.wr_en && (wr.wr_x >= X_LO) && (wr.wr_x < X_HI)
                              && (wr.wr_y >= Y_LO) && (wr.wr_y < Y_HI);
    assign wr_addr = ADDR_W'(wr.wr_y - Y_LO) * ADDR_W'(W) + ADDR_W'(wr.wr_x - X_LO);

    assign pix_in_region = (hcount >= X_LO) && (hcount < X_HI)
                        && (vcount >= Y_LO) && (vcount < Y_HI);
    assign rd_addr = ADDR_W'(vcount - Y_LO) * ADDR_W'(W) + ADDR_W'(hcount - X_LO);

    always_ff @(posedge clk) begin
        if (wr_hit) mem[wr_addr] <= wr.wr_color;
    end

    // Read only on the clk after stage A loads, so a write landing later in the
    // same pixel slot cannot change a pixel that is already on screen.
    always_ff @(posedge clk) begin
        if (a_load) rd_data <= mem[a_addr];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_load    <= 1'b0;
            a_tick    <= 1'b0;
            a_in      <= 1'b0;
            a_addr    <= '0;
            a_hs      <= 1'b1;
            a_vs      <= 1'b1;
            a_blank_n <= 1'b0;
        end else begin
            a_load <= pix_en;
            a_tick <= pix_en && (hcount == '0) && (vcount == '0);
            if (pix_en) begin
                a_in      <= pix_in_region;
                a_addr    <= pix_in_region ? rd_addr : '0;
                a_hs      <= !((hcount >= H_SYNC_LO) && (hcount < H_SYNC_HI));
                a_vs      <= !((vcount >= V_SYNC_LO) && (vcount < V_SYNC_HI));
                a_blank_n <= (hcount < H_ACT) && (vcount < V_ACT);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            b_tick    <= 1'b0;
            b_in      <= 1'b0;
            b_hs      <= 1'b1;
            b_vs      <= 1'b1;
            b_blank_n <= 1'b0;
        end else begin
            b_tick <= a_tick;
            if (a_load) begin
                b_in      <= a_in;
                b_hs      <= a_hs;
                b_vs      <= a_vs;
                b_blank_n <= a_blank_n;
            end
        end
    end

    // Blanking forces black regardless of BG, and also covers the reset state.
    assign pix_rgb = !b_blank_n          ? 8'h00 :
                     (b_in && rd_data)   ? FG    : BG;

    assign vga_hs      = b_hs;
    assign vga_vs      = b_vs;
    assign vga_blank_n = b_blank_n;
    assign vga_r       = pix_rgb;
    assign vga_g       = pix_rgb;
    assign vga_b       = pix_rgb;
    assign frame_tick  = b_tick;
endmodule

// File: tb/tb_puzzle_vga_scanout.sv
// Randomized bench for puzzle_vga_scanout: a scaled-down instance checked every clk
// against a screen-coordinate reference model, plus a full-size instance for line timing.
module tb_puzzle_vga_scanout;
    localparam int X0 = 8, Y0 = 4, W = 20, H = 12, P = 2;
    localparam int HA = 40, HFP = 4, HSY = 6, HBP = 6, HT = HA + HFP + HSY + HBP;
    localparam int VA = 20, VFP = 2, VSY = 2, VBP = 3, VT = VA + VFP + VSY + VBP;
    localparam int FRAME = HT * VT * P;
    localparam logic [7:0] FG = 8'hE7, BG = 8'h21;

    typedef struct packed {
        logic        en;
        logic [10:0] x;
        logic [10:0] y;
        logic        c;
    } wr_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic       vga_hs, vga_vs, vga_blank_n, frame_tick;
    logic [7:0] vga_r, vga_g, vga_b;
    logic       d_hs, d_vs, d_blank_n, d_tick;
    logic [7:0] d_r, d_g, d_b;

    puzzle_vga_scanout_if wr_bus();
    puzzle_vga_scanout_if idle_bus();

    assign idle_bus.wr_en    = 1'b0;
    assign idle_bus.wr_x     = 11'd0;
    assign idle_bus.wr_y     = 11'd0;
    assign idle_bus.wr_color = 1'b0;

    puzzle_vga_scanout #(
        .X0(X0), .Y0(Y0), .W(W), .H(H), .CLK_PER_PIX(P), .FG(FG), .BG(BG),
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP)
    ) dut (
        .clk(clk), .reset(reset), .wr(wr_bus),
        .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .frame_tick(frame_tick)
    );

    puzzle_vga_scanout std_dut (
        .clk(clk), .reset(reset), .wr(idle_bus),
        .vga_hs(d_hs), .vga_vs(d_vs), .vga_blank_n(d_blank_n),
        .vga_r(d_r), .vga_g(d_g), .vga_b(d_b), .frame_tick(d_tick)
    );

    always #5 clk = ~clk;

    int   total = 0;
    int   bad = 0;
    int   n;
    bit   inReset;
    bit   fb    [0:H-1][0:W-1];
    bit   known [0:H-1][0:W-1];
    logic [2:0] snapSync;
    logic [7:0] snapRgb;
    bit   snapRgbKnown;
    bit   snapTick;
    wr_t  q[$];

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s cycle=%0d got=%h want=%h", tag, n, obs, exp);
        end
    endtask

    task automatic applyStimulus(input wr_t w);
        wr_bus.wr_en    = w.en;
        wr_bus.wr_x     = w.x;
        wr_bus.wr_y     = w.y;
        wr_bus.wr_color = w.c;
    endtask

    function automatic wr_t mk(input int x, input int y, input bit c);
        wr_t w;
        w.en = 1'b1;
        w.x  = 11'(x);
        w.y  = 11'(y);
        w.c  = c;
        return w;
    endfunction

    // Pixel presented in cycle c = kP is fetched at the edge ending c+1 and shown in
    // cycles c+2 .. c+P+1; so the snapshot is taken before that edge's write lands.
    task automatic modelEdge(input wr_t w);
        int c, p, h, v, wx, wy;
        bit act, inR;
        if (n >= 1 && (n - 1) % P == 0) begin
            c = n - 1;
            p = c / P;
            h = p % HT;
            v = (p / HT) % VT;
            act = (h < HA) && (v < VA);
            inR = (h >= X0) && (h < X0 + W) && (v >= Y0) && (v < Y0 + H);
            snapSync = {!(h >= HA + HFP && h < HA + HFP + HSY),
                        !(v >= VA + VFP && v < VA + VFP + VSY), act};
            snapTick = (h == 0) && (v == 0);
            snapRgbKnown = 1'b1;
            if (!act) snapRgb = 8'h00;
            else if (!inR) snapRgb = BG;
            else begin
                snapRgb = fb[v - Y0][h - X0] ? FG : BG;
                snapRgbKnown = known[v - Y0][h - X0];
            end
        end
        wx = int'(w.x);
        wy = int'(w.y);
        if (w.en && wx >= X0 && wx < X0 + W && wy >= Y0 && wy < Y0 + H) begin
            fb[wy - Y0][wx - X0] = w.c;
            known[wy - Y0][wx - X0] = 1'b1;
        end
        n++;
    endtask

    task automatic checkCycle();
        logic [3:0] expSync;
        logic [7:0] expRgb;
        bit rgbKnown;
        if (inReset || n < 2) begin
            expSync = 4'b1100;
            expRgb = 8'h00;
            rgbKnown = 1'b1;
        end else begin
            expSync = {snapSync, snapTick && ((n - 2) % P == 0)};
            expRgb = snapRgb;
            rgbKnown = snapRgbKnown;
        end
        checkOutput("sync", 32'({vga_hs, vga_vs, vga_blank_n, frame_tick}), 32'(expSync));
        if (rgbKnown)
            checkOutput("rgb", 32'({vga_r, vga_g, vga_b}), 32'({expRgb, expRgb, expRgb}));
    endtask

    task automatic stepCycle();
        wr_t w;
        if (q.size() > 0) w = q.pop_front();
        else w = '0;
        applyStimulus(w);
        @(posedge clk);
        modelEdge(w);
        #1;
        checkCycle();
    endtask

    task automatic runCycles(input int k);
        repeat (k) stepCycle();
    endtask

    task automatic pushSweep(input bit c);
        for (int y = Y0; y < Y0 + H; y++)
            for (int x = X0; x < X0 + W; x++)
                q.push_back(mk(x, y, c));
    endtask

    task automatic midFrameReset(input int hh, input int vv);
        int guard;
        guard = 0;
        while (!(n % P == 0 && (n / P) % HT == hh && (n / P / HT) % VT == vv) && guard < 2 * FRAME) begin
            stepCycle();
            guard++;
        end
        checkOutput("rst_seek", 32'(guard < 2 * FRAME), 1);
        applyStimulus('0);
        reset = 1'b0;
        inReset = 1'b1;
        #1;
        checkCycle();
        repeat (3) begin
            @(posedge clk);
            #1;
            checkCycle();
        end
        reset = 1'b1;
        inReset = 1'b0;
        n = 0;
        checkCycle();
    endtask

    initial begin
        wr_t w;
        applyStimulus('0);
        inReset = 1'b1;
        n = 0;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) begin
                fb[y][x] = 1'b0;
                known[y][x] = 1'b0;
            end
        repeat (3) @(posedge clk);
        #1;
        checkCycle();

        // Clear, then boundary writes: corners in, neighbours just outside dropped.
        pushSweep(1'b0);
        q.push_back(mk(X0 + W - 1, Y0 + H - 1, 1'b1));
        q.push_back(mk(X0 - 1, Y0, 1'b1));
        q.push_back(mk(X0 + W, Y0, 1'b1));
        q.push_back(mk(X0, Y0 + H, 1'b1));
        q.push_back(mk(X0, Y0 - 1, 1'b1));
        q.push_back(mk(2047, 2047, 1'b1));
        reset = 1'b1;
        inReset = 1'b0;
        checkCycle();
        runCycles(2 * FRAME);

        q.push_back(mk(X0, Y0, 1'b1));
        for (int i = 0; i < 1500; i++) begin
            w.en = 1'($urandom_range(0, 1));
            w.x  = 11'($urandom_range(X0 - 3, X0 + W + 2));
            w.y  = 11'($urandom_range(Y0 - 2, Y0 + H + 1));
            w.c  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 31) == 0) w.x = 11'($urandom);
            q.push_back(w);
        end
        runCycles(2 * FRAME);

        for (int i = 0; i < 200; i++)
            q.push_back(mk(int'($urandom_range(X0, X0 + W - 1)), int'($urandom_range(Y0, Y0 + H - 1)), 1'b1));
        pushSweep(1'b0);
        runCycles(2 * FRAME);

        midFrameReset(30, 10);
        runCycles(FRAME + 100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Full-size instance: line timing from the first pixel tick after release.
    initial begin
        int fall1, rise1, fall2;
        logic prevHs;
        fall1 = -1;
        rise1 = -1;
        fall2 = -1;
        @(posedge reset);
        prevHs = 1'b1;
        for (int k = 1; k <= 3400; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) checkOutput("std_blank_c1", 32'(d_blank_n), 0);
            if (k == 2) begin
                checkOutput("std_tick_c2", 32'(d_tick), 1);
                checkOutput("std_blank_c2", 32'(d_blank_n), 1);
                checkOutput("std_rgb_c2", 32'({d_r, d_g, d_b}), 0);
            end
            if (k == 3) checkOutput("std_tick_c3", 32'(d_tick), 0);
            if (prevHs && !d_hs) begin
                if (fall1 < 0) fall1 = k;
                else if (fall2 < 0) fall2 = k;
            end
            if (!prevHs && d_hs && rise1 < 0) rise1 = k;
            prevHs = d_hs;
        end
        checkOutput("std_vs", 32'(d_vs), 1);
        checkOutput("std_hs_first", fall1, 656 * 2 + 2);
        checkOutput("std_hs_width", rise1 - fall1, 96 * 2);
        checkOutput("std_line", fall2 - fall1, 1600);
    end
endmodule
